// File: rtl/blockmem_16kx1.sv
// Single-port synchronous block RAM: 2048 x 16, registered read, write-first.
// douta clears asynchronously on reset; the array contents survive reset.
module blockmem_16kx1 #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 2048
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic [0:0]            wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta
);

  // Zero at configuration time; there is deliberately no reset path into the array.
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1] = '{default: '0};
  logic [DATA_WIDTH-1:0] r_douta;
  logic                  w_we;

  // rsta_n is sampled at the edge, so a reset that falls before an edge blocks that write.
  assign w_we = wea[0] & rsta_n;

  always_ff @(posedge clka) begin
    if (w_we) begin
      r_mem[addra] <= dina;
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_douta <= '0;
    end else if (wea[0]) begin
      r_douta <= dina;
    end else begin
      r_douta <= r_mem[addra];
    end
  end

  assign douta = r_douta;

endmodule

// File: tb/tb_blockmem_16kx1.sv
// Bench for blockmem_16kx1: directed vector table, reset sequences, and
// random traffic scored against an array model of the memory.
module tb_blockmem_16kx1;

  localparam int DW = 16;
  localparam int AW = 11;
  localparam int DEPTH = 2048;

  logic          clka;
  logic          rsta_n;
  logic [0:0]    wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [DW-1:0] douta;

  blockmem_16kx1 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clka   (clka),
    .rsta_n (rsta_n),
    .wea    (wea),
    .addra  (addra),
    .dina   (dina),
    .douta  (douta)
  );

  // clock / reset
  initial clka = 1'b0;
  always #10 clka = ~clka;

  // scoreboard state
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: douta=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one access at the falling edge; douta is sampled at the next falling edge.
  task automatic drive(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    @(negedge clka);
    wea   = we;
    addra = addr;
    dina  = din;
    @(negedge clka);
  endtask

  // Access through the model: the expected output follows write-first semantics.
  task automatic model_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    if (we) begin
      exp_q.push_back(din);
      model_mem[addr] = din;
    end else begin
      exp_q.push_back(model_mem[addr]);
    end
    drive(we, addr, din);
    check("scoreboard", douta, exp_q.pop_front());
  endtask

  task automatic add_vec(input logic we, input int addr, input int din, input int exp);
    vec_t v;
    v.we = we;
    v.addr = AW'(addr);
    v.din = DW'(din);
    v.exp = DW'(exp);
    vecs.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    wea = 1'b0;
    addra = '0;
    dina = '0;
    rsta_n = 1'b1;

    // power-up reset, 100 ns, douta must stay 0 throughout
    #1 rsta_n = 1'b0;
    wea = 1'b1;
    addra = AW'(5);
    dina = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      #20;
      check("powerup_reset", douta, 16'h0000);
    end
    @(negedge clka);
    wea = 1'b0;
    rsta_n = 1'b1;

    // directed vectors
    add_vec(0, 5, 16'h0000, 16'h0000);
    add_vec(1, 5, 13, 13);
    add_vec(0, 5, 16'hDEAD, 13);
    add_vec(1, 0, 16'hA5A5, 16'hA5A5);
    add_vec(1, 2047, 16'h5A5A, 16'h5A5A);
    add_vec(0, 0, 16'h1234, 16'hA5A5);
    add_vec(0, 2047, 16'h0000, 16'h5A5A);
    add_vec(0, 1, 16'hFFFF, 16'h0000);
    for (int i = 0; i < 4; i++) add_vec(1, 10 + i, 100 + i, 100 + i);
    for (int i = 3; i >= 0; i--) add_vec(0, 10 + i, 16'h0000, 100 + i);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].we) model_mem[vecs[i].addr] = vecs[i].din;
      drive(vecs[i].we, vecs[i].addr, vecs[i].din);
      check($sformatf("vec%0d", i), douta, vecs[i].exp);
    end

    // reset mid-cycle: douta drops before the next edge, writes blocked, contents kept
    drive(1, 7, 16'hBEEF);
    model_mem[7] = 16'hBEEF;
    check("write_beef", douta, 16'hBEEF);
    #3 rsta_n = 1'b0;
    #1 check("async_reset_drop", douta, 16'h0000);
    wea = 1'b1;
    addra = AW'(7);
    dina = 16'h1111;
    @(negedge clka);
    check("reset_hold_1", douta, 16'h0000);
    @(negedge clka);
    check("reset_hold_2", douta, 16'h0000);
    wea = 1'b0;
    rsta_n = 1'b1;
    drive(0, 7, 16'h0000);
    check("after_reset_read7", douta, 16'hBEEF);

    // reset falling just before an edge that would write
    @(negedge clka);
    wea = 1'b1;
    addra = AW'(7);
    dina = 16'h2222;
    #9 rsta_n = 1'b0;
    @(negedge clka);
    wea = 1'b0;
    rsta_n = 1'b1;
    drive(0, 7, 16'h0000);
    check("late_reset_blocks_write", douta, 16'hBEEF);

    // read-only stability and no combinational path from addra/dina
    for (int i = 0; i < 20; i++) begin
      @(negedge clka);
      wea = 1'b0;
      addra = AW'(5);
      dina = DW'($urandom);
      #5 dina = DW'($urandom);
      @(negedge clka);
      check("stable_read5", douta, 16'd13);
    end
    addra = AW'(2047);
    #2 check("no_comb_path", douta, 16'd13);

    // random traffic against the array model, addresses biased to collide
    for (int i = 0; i < 400; i++) begin
      logic          we;
      logic [AW-1:0] a;
      we = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: a = AW'($urandom_range(0, 15));
        1: a = AW'($urandom_range(2040, 2047));
        default: a = AW'($urandom_range(0, DEPTH - 1));
      endcase
      model_access(we, a, DW'($urandom));
    end

    // final sweep of the directed locations
    model_access(0, 0, 0);
    model_access(0, 2047, 0);
    model_access(0, 5, 0);
    model_access(0, 7, 0);
    for (int i = 10; i < 14; i++) model_access(0, AW'(i), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
